soc_system_led_sequencer: RTL and testbench
===========================================

// Module: soc_system_led_sequencer
// PURPOSE
//  Downstream of the 5-bit LED PIO: consumes its out_port as a command word and drives board LEDs with
//  timed patterns (off, blink, bouncing scan, PWM-dimmed bar). Lets software set an animation with one
//  Avalon write; all timing is in hardware. Same clock domain as the PIO; leds go straight to pins.
// PARAMETERS
//  NUM_LEDS    10      LED count driven (>=2)
//  TICK_DIV    50000   clk cycles per base tick (1 ms at 50 MHz), >=1
//  STEP_TICKS  100     base ticks per pattern step at speed arg=0, >=1
// PORTS
//  clk      in   1         system clock
//  reset    in   1         asynchronous, active-high reset
//  cmd      in   5         from PIO out_port: cmd[4:3]=mode, cmd[2:0]=arg
//  leds     out  NUM_LEDS  LED drive, 1=on, registered
//  step     out  1         one-clk pulse on every pattern step (debug/IRQ hook), registered
// BEHAVIOUR
//  Reset: leds=0, step=0, cmd_q=0, tick_cnt=0, step_cnt=0, pos=0, dir=up, phase=1, pwm_cnt=0.
//  Modes: 0 OFF, 1 BLINK, 2 SCAN, 3 BAR (PWM).
//  Change detect: cmd_q<=cmd each clk; cmd!=cmd_q => restart on that edge: tick_cnt, step_cnt,
//   pwm_cnt, pos cleared, dir=up, phase=1. Any change, incl. arg only, restarts. leds shows new
//   pattern exactly 2 clks after cmd changes. Reset release with cmd!=0 restarts normally.
//  Tick: tick_cnt counts 0..TICK_DIV-1, tick=1 when tick_cnt==TICK_DIV-1 (then wraps to 0).
//  Step: on tick, step_cnt counts 0..(arg+1)*STEP_TICKS-1; step asserted the cycle after terminal
//   count; step period = TICK_DIV*STEP_TICKS*(arg+1) clks; first step that long after restart.
//   step_cnt width = $clog2(8*STEP_TICKS); multiply done on 3-bit arg, no overflow allowed.
//  OFF: leds=0; counters run, step pulses still emitted.
//  BLINK: on step phase toggles; leds = {NUM_LEDS{phase}}; starts ON after restart.
//  SCAN: leds = one-hot at pos. On step: dir up: pos==NUM_LEDS-1 -> pos-1, dir=down, else pos+1;
//   dir down: pos==0 -> pos+1, dir=up, else pos-1. Ends never dwell twice (0,1,..,N-1,N-2,..,0,1).
//  BAR: pwm_cnt advances on every tick, wraps 6->0 (period 7 ticks); leds = all-on when pwm_cnt<arg,
//   else 0. arg=0 always off, arg=7 always on; step still pulses on step schedule.
//  Simultaneous restart and tick/step: restart wins, no step pulse, no pos/phase update.
//  Reset mid-pattern: all state to reset values immediately (async), leds=0 same instant.
// STRUCTURE
//  soc_system_led_pkg: mode localparams MODE_OFF/BLINK/SCAN/BAR (2-bit), CMD field positions.
//  Sub-module soc_system_led_tick_gen (tick_cnt prescaler, TICK_DIV param, sync clear input,
//   tick out); sequencer keeps step_cnt, pos/dir, phase, pwm_cnt and output registers.
// TESTING (bench: NUM_LEDS=4, TICK_DIV=2, STEP_TICKS=2 -> step period 4*(arg+1) clks)
//  1 reset asserted mid-SCAN -> leds=0000, step=0 immediately; release with cmd=0 -> stays 0000.
//  2 cmd=5'b10_000 (SCAN,arg0) -> leds 0001 after 2 clks, then every 4 clks:
//    0010,0100,1000,0100,0010,0001,0010; step pulses 1 clk each change.
//  3 cmd=5'b01_001 (BLINK,arg1) -> leds 1111 for 8 clks, 0000 for 8 clks, repeating.
//  4 cmd=5'b11_011 (BAR,arg3) -> over 14 clks leds=1111 for 6, 0000 for 8; arg7 -> constant 1111;
//    arg0 -> constant 0000.
//  5 in SCAN at pos 2 change arg 0->1 -> restart: leds 0001 2 clks later, next step after 8 clks;
//    cmd change on same edge as step -> no step pulse, pos reset.
//  6 cmd=5'b00_111 (OFF) -> leds 0000, step pulses every 32 clks.

Source files
------------

// File: rtl/soc_system_led_pkg.sv
// Shared definitions for the LED sequencer: command word layout, mode codes and scan direction.
package soc_system_led_pkg;

  localparam int CMD_W        = 5;
  localparam int CMD_MODE_LSB = 3;
  localparam int CMD_ARG_LSB  = 0;
  localparam int PWM_LAST     = 6;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_BAR   = 2'd3;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  function automatic logic [1:0] cmd_mode(input logic [CMD_W-1:0] c);
    return c[CMD_MODE_LSB +: 2];
  endfunction

  function automatic logic [2:0] cmd_arg(input logic [CMD_W-1:0] c);
    return c[CMD_ARG_LSB +: 3];
  endfunction

endpackage

// File: rtl/soc_system_led_tick_gen.sv
// Base-tick prescaler: pulses tick for one clk every TICK_DIV clks; clear restarts the count.
module soc_system_led_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] tick_cnt;

  assign tick = (tick_cnt == CW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              tick_cnt <= '0;
    else if (clear || tick) tick_cnt <= '0;
    else                    tick_cnt <= tick_cnt + CW'(1);
  end

endmodule

// File: rtl/soc_system_led_sequencer.sv
// LED animation engine driven by the PIO command word; any command change restarts the animation.
module soc_system_led_sequencer
  import soc_system_led_pkg::*;
#(
  parameter int NUM_LEDS   = 10,
  parameter int TICK_DIV   = 50000,
  parameter int STEP_TICKS = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CMD_W-1:0]    cmd,
  output logic [NUM_LEDS-1:0] leds,
  output logic                step
);

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int SW = $clog2(8 * STEP_TICKS);

  logic [CMD_W-1:0]    cmd_q;
  logic [SW-1:0]       step_cnt;
  logic [PW-1:0]       pos;
  dir_e                dir;
  logic                phase;
  logic [2:0]          pwm_cnt;
  logic                restart;
  logic                tick;
  logic [1:0]          mode;
  logic [2:0]          arg;
  logic [SW-1:0]       step_last;
  logic [NUM_LEDS-1:0] pattern;

  assign restart   = (cmd != cmd_q);
  assign mode      = cmd_mode(cmd_q);
  assign arg       = cmd_arg(cmd_q);
  assign step_last = SW'((int'(arg) + 1) * STEP_TICKS - 1);

  soc_system_led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .tick  (tick)
  );

  // NOTE: default assignment first so no path through the case leaves pattern unassigned (no latch).
  always_comb begin
    pattern = '0;
    case (mode)
      MODE_OFF:   pattern = '0;
      MODE_BLINK: pattern = {NUM_LEDS{phase}};
      MODE_SCAN:  pattern = NUM_LEDS'(1) << pos;
      MODE_BAR:   pattern = (pwm_cnt < arg) ? '1 : '0;
      default:    pattern = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q    <= '0;
      leds     <= '0;
      step     <= 1'b0;
      step_cnt <= '0;
      pos      <= '0;
      dir      <= DIR_UP;
      phase    <= 1'b1;
      pwm_cnt  <= '0;
    end else begin
      cmd_q <= cmd;
      leds  <= pattern;
      step  <= 1'b0;
      // Restart takes priority over a coincident tick or step.
      if (restart) begin
        step_cnt <= '0;
        pos      <= '0;
        dir      <= DIR_UP;
        phase    <= 1'b1;
        pwm_cnt  <= '0;
      end else if (tick) begin
        pwm_cnt <= (pwm_cnt == 3'(PWM_LAST)) ? 3'd0 : pwm_cnt + 3'd1;
        if (step_cnt == step_last) begin
          step_cnt <= '0;
          step     <= 1'b1;
          phase    <= ~phase;
          if (dir == DIR_UP) begin
            if (pos == PW'(NUM_LEDS - 1)) begin
              pos <= pos - PW'(1);
              dir <= DIR_DOWN;
            end else begin
              pos <= pos + PW'(1);
            end
          end else begin
            if (pos == '0) begin
              pos <= pos + PW'(1);
              dir <= DIR_UP;
            end else begin
              pos <= pos - PW'(1);
            end
          end
        end else begin
          step_cnt <= step_cnt + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_soc_system_led_sequencer.sv
// Self-checking bench: directed and random command sequences against a time-since-restart model.
module tb_soc_system_led_sequencer;

  localparam int N  = 4;
  localparam int TD = 2;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [4:0]   cmd = '0;
  logic [N-1:0] leds;
  logic         step;

  int         errors = 0;
  int         checks = 0;
  logic [4:0] m_q = '0;   // command the model believes is registered
  int         k = 0;      // edges since last restart (or reset release)

  soc_system_led_sequencer #(
    .NUM_LEDS   (N),
    .TICK_DIV   (TD),
    .STEP_TICKS (ST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd),
    .leds  (leds),
    .step  (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int period(input logic [4:0] c);
    int a;
    a = int'(c[2:0]);
    return TD * ST * (a + 1);
  endfunction

  // Pattern visible after edge kk: reflects steps/ticks completed by edge kk-1.
  function automatic logic [N-1:0] model_leds(input logic [4:0] c, input int kk);
    int mode, a, s, t, m, p;
    mode = int'(c[4:3]);
    a    = int'(c[2:0]);
    s    = (kk - 1) / period(c);
    t    = (kk - 1) / TD;
    case (mode)
      0: return '0;
      1: return (s % 2 == 0) ? '1 : '0;
      2: begin
        m = s % (2 * N - 2);
        p = (m < N) ? m : (2 * N - 2 - m);
        return N'(1) << p;
      end
      default: return ((t % 7) < a) ? '1 : '0;
    endcase
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (cmd !== m_q) begin
        m_q = cmd;
        k   = 0;
      end else begin
        k++;
      end
      @(negedge clk);
      check($sformatf("step cmd=%b k=%0d", m_q, k), 32'(step),
            32'(k > 0 && (k % period(m_q)) == 0));
      if (k >= 1)
        check($sformatf("leds cmd=%b k=%0d", m_q, k), 32'(leds), 32'(model_leds(m_q, k)));
    end
  endtask

  // Called at a negedge; asserts reset off-edge, checks the async clear, releases with hold_cmd.
  task automatic do_reset(input logic [4:0] hold_cmd);
    #2 reset = 1'b1;
    #1;
    check("reset_async_leds", 32'(leds), 32'(0));
    check("reset_async_step", 32'(step), 32'(0));
    cmd = hold_cmd;
    @(negedge clk);
    reset = 1'b0;
    m_q   = '0;
    k     = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_leds", 32'(leds), 32'(0));
    check("reset_step", 32'(step), 32'(0));
    reset = 1'b0;

    // SCAN arg0: bounce sequence with 4-clk steps
    cmd = 5'b10_000;
    cycles(34);

    // Reset mid-SCAN, release with OFF
    do_reset(5'b00_000);
    cycles(10);

    // BLINK arg1: 8 on / 8 off
    cmd = 5'b01_001;
    cycles(36);

    // BAR duty 3/7, then full on, then full off
    cmd = 5'b11_011;
    cycles(30);
    cmd = 5'b11_111;
    cycles(16);
    cmd = 5'b11_000;
    cycles(16);

    // SCAN reaches pos 2, then arg-only change restarts
    cmd = 5'b10_000;
    cycles(10);
    cmd = 5'b10_001;
    cycles(12);

    // Command change lands on the edge a step would occur
    cmd = 5'b10_000;
    cycles(4);
    cmd = 5'b10_010;
    cycles(8);

    // OFF arg7: dark, step every 32 clks
    cmd = 5'b00_111;
    cycles(70);

    // Reset release with a non-zero command restarts normally
    do_reset(5'b10_001);
    cycles(20);

    // Random command segments, some repeating the current command
    for (int seg = 0; seg < 40; seg++) begin
      if ($urandom_range(0, 3) == 0) cmd = m_q;
      else                           cmd = 5'($urandom_range(0, 31));
      cycles(int'($urandom_range(1, 40)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
